// File: rtl/fp_mult_pkg.sv
// Shared types and format helpers for the pipelined IEEE-754 multiplier.
package fp_mult_pkg;

  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN} fp_cls_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fp_spec_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic zero;
    logic nan;
    logic inexact;
  } fp_flags_t;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_emax(input int exp_w);
    return fp_bias(exp_w);
  endfunction

  function automatic int fp_emin(input int exp_w);
    return 1 - fp_bias(exp_w);
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, only the fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < exp_w; i++) q[man_w+i] = 1'b1;
    q[man_w-1] = 1'b1;
    return q;
  endfunction

  function automatic fp_cls_e fp_classify(input logic exp_zero, input logic exp_ones,
                                          input logic frac_zero);
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    if (exp_zero) return frac_zero ? CLS_ZERO : CLS_SUB;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_lzc.sv
// Leading-zero counter used to normalise subnormal significands.
module fp_lzc
  import fp_mult_pkg::*;
#(
  parameter int WIDTH = 10,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754 multiplier (unpack / multiply / round) with RNE,
// subnormal support, exception flags and a single global stall enable.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = fp_width(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         zero,
  output logic         nan,
  output logic         inexact
);

  localparam int BIAS = fp_bias(EXP_W);
  localparam int EMAX = fp_emax(EXP_W);
  localparam int EMIN = fp_emin(EXP_W);
  localparam int XW   = EXP_W + 3;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int LZW  = $clog2(MAN_W + 1);
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

  function automatic logic rne_inc(input logic lsb, input logic guard, input logic rnd,
                                   input logic sticky);
    return guard & (rnd | sticky | lsb);
  endfunction

  function automatic logic [W-1:0] inf_word(input logic sign);
    return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // ---- S1: classify, normalise subnormals, add exponents, resolve specials
  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      fa, fb;
  fp_cls_e               cls_a, cls_b;
  logic [LZW-1:0]        lz_a, lz_b;
  logic [MAN_W:0]        sig_a, sig_b;
  logic signed [XW-1:0]  exp_a, exp_b;
  fp_spec_t              spec_s1;

  assign ea    = a[W-2:MAN_W];
  assign eb    = b[W-2:MAN_W];
  assign fa    = a[MAN_W-1:0];
  assign fb    = b[MAN_W-1:0];
  assign cls_a = fp_classify(ea == '0, &ea, fa == '0);
  assign cls_b = fp_classify(eb == '0, &eb, fb == '0);

  fp_lzc #(.WIDTH(MAN_W)) u_lzc_a (.value(fa), .count(lz_a));
  fp_lzc #(.WIDTH(MAN_W)) u_lzc_b (.value(fb), .count(lz_b));

  always_comb begin
    sig_a = {1'b1, fa};
    exp_a = $signed({3'b000, ea}) - XW'(BIAS);
    if (cls_a == CLS_SUB) begin
      sig_a = {1'b0, fa} << (lz_a + 1'b1);
      exp_a = XW'(EMIN - 1) - XW'(lz_a);
    end
    sig_b = {1'b1, fb};
    exp_b = $signed({3'b000, eb}) - XW'(BIAS);
    if (cls_b == CLS_SUB) begin
      sig_b = {1'b0, fb} << (lz_b + 1'b1);
      exp_b = XW'(EMIN - 1) - XW'(lz_b);
    end
    spec_s1.nan  = (cls_a == CLS_NAN) | (cls_b == CLS_NAN) |
                   ((cls_a == CLS_INF) & (cls_b == CLS_ZERO)) |
                   ((cls_a == CLS_ZERO) & (cls_b == CLS_INF));
    spec_s1.inf  = ((cls_a == CLS_INF) | (cls_b == CLS_INF)) & ~spec_s1.nan;
    spec_s1.zero = ((cls_a == CLS_ZERO) | (cls_b == CLS_ZERO)) & ~spec_s1.nan;
  end

  logic                 vld_p0, vld_p1;
  logic                 sign_p0, sign_p1;
  logic signed [XW-1:0] exp_p0, exp_p1;
  logic [MAN_W:0]       sig_a_p0, sig_b_p0;
  logic [PW-1:0]        prod_p1;
  fp_spec_t             spec_p0, spec_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sign_p0  <= a[W-1] ^ b[W-1];
      exp_p0   <= exp_a + exp_b;
      sig_a_p0 <= sig_a;
      sig_b_p0 <= sig_b;
      spec_p0  <= spec_s1;
      // ---- S2: significand product
      sign_p1  <= sign_p0;
      exp_p1   <= exp_p0;
      prod_p1  <= PW'(sig_a_p0) * PW'(sig_b_p0);
      spec_p1  <= spec_p0;
    end
  end

  // ---- S3: normalise, denormalise below emin, round RNE, pack
  int                e_n, e_r, shamt;
  logic [PW-1:0]     norm, shifted;
  logic [2*PW-1:0]   ext;
  logic [MAN_W:0]    kept;
  logic              g, r, s, inc, hidden;
  logic [MAN_W+1:0]  mant;
  logic [MAN_W-1:0]  frac;
  logic [EXP_W-1:0]  e_field;
  logic [W-1:0]      res_s3;
  fp_flags_t         fl_s3;

  always_comb begin
    norm  = prod_p1[PW-1] ? prod_p1 : (prod_p1 << 1);
    e_n   = int'(exp_p1) + int'(prod_p1[PW-1]);
    shamt = EMIN - e_n;
    if (shamt > PW) shamt = PW;
    if (shamt < 0) shamt = 0;
    e_r     = (e_n < EMIN) ? EMIN : e_n;
    ext     = {norm, {PW{1'b0}}} >> shamt;
    shifted = ext[2*PW-1:PW];
    kept    = shifted[PW-1:MAN_W+1];
    g       = shifted[MAN_W];
    r       = shifted[MAN_W-1];
    s       = (|shifted[MAN_W-2:0]) | (|ext[PW-1:0]);
    inc     = rne_inc(kept[0], g, r, s);
    mant    = {1'b0, kept} + {{(MAN_W+1){1'b0}}, inc};
    hidden  = mant[MAN_W+1] | mant[MAN_W];
    if (mant[MAN_W+1]) e_r = e_r + 1;
    frac    = mant[MAN_W+1] ? '0 : mant[MAN_W-1:0];
    e_field = hidden ? EXP_W'(e_r + BIAS) : '0;
    res_s3  = {sign_p1, e_field, frac};
    fl_s3           = '0;
    fl_s3.inexact   = g | r | s;
    fl_s3.zero      = ~hidden & (frac == '0);
    fl_s3.underflow = ~hidden & fl_s3.inexact;
    if (e_r > EMAX) begin
      res_s3         = inf_word(sign_p1);
      fl_s3          = '0;
      fl_s3.overflow = 1'b1;
      fl_s3.inexact  = 1'b1;
    end
    if (spec_p1.nan) begin
      res_s3    = QNAN;
      fl_s3     = '0;
      fl_s3.nan = 1'b1;
    end else if (spec_p1.inf) begin
      res_s3 = inf_word(sign_p1);
      fl_s3  = '0;
    end else if (spec_p1.zero) begin
      res_s3     = {sign_p1, {(W-1){1'b0}}};
      fl_s3      = '0;
      fl_s3.zero = 1'b1;
    end
  end

  logic [W-1:0] res_p2;
  fp_flags_t    flags_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res_p2    <= '0;
      flags_p2  <= '0;
    end else if (en) begin
      out_valid <= vld_p1;
      res_p2    <= res_s3;
      flags_p2  <= fl_s3;
    end
  end

  assign result    = res_p2;
  assign overflow  = out_valid & flags_p2.overflow;
  assign underflow = out_valid & flags_p2.underflow;
  assign zero      = out_valid & flags_p2.zero;
  assign nan       = out_valid & flags_p2.nan;
  assign inexact   = out_valid & flags_p2.inexact;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe in its FP16 configuration.
module tb_fp_mult_pipe;

  localparam int BIAS  = 15;
  localparam int MAN_W = 10;
  localparam int EMIN  = -14;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        overflow, underflow, zero, nan, inexact;
  logic [4:0]  fl_now;

  assign fl_now = {overflow, underflow, zero, nan, inexact};

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow),
    .zero(zero), .nan(nan), .inexact(inexact)
  );

  typedef struct {
    logic [15:0] res;
    logic [4:0]  fl;   // {overflow, underflow, zero, nan, inexact}
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  fl;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  bit   sb_en = 0;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Exact product as integer significand * 2^pe, then rounded to the
  // FP16 quantum for its binade with round-half-even.
  function automatic exp_t ref_mul(input logic [15:0] x, input logic [15:0] y);
    exp_t   rv;
    logic   s;
    int     ex, ey, fx, fy, pe, msb, e_top, qe, sh, fld;
    longint p, q, rem, half;
    bit     ix, nx, ny, ix_inf, iy_inf, zx, zy;
    s  = x[15] ^ y[15];
    ex = int'(x[14:10]); ey = int'(y[14:10]);
    fx = int'(x[9:0]);   fy = int'(y[9:0]);
    nx = (ex == 31) && (fx != 0);   ny = (ey == 31) && (fy != 0);
    ix_inf = (ex == 31) && (fx == 0); iy_inf = (ey == 31) && (fy == 0);
    zx = (ex == 0) && (fx == 0);    zy = (ey == 0) && (fy == 0);
    if (nx || ny || (ix_inf && zy) || (iy_inf && zx)) begin
      rv = '{16'h7E00, 5'b00010};
    end else if (ix_inf || iy_inf) begin
      rv = '{{s, 15'h7C00}, 5'b00000};
    end else if (zx || zy) begin
      rv = '{{s, 15'h0000}, 5'b00100};
    end else begin
      p  = longint'((ex == 0) ? fx : fx + 1024) * longint'((ey == 0) ? fy : fy + 1024);
      pe = ((ex == 0) ? 1 : ex) - BIAS - MAN_W + ((ey == 0) ? 1 : ey) - BIAS - MAN_W;
      msb = 0;
      for (int i = 0; i < 62; i++) if (p[i]) msb = i;
      e_top = msb + pe;
      qe = ((e_top < EMIN) ? EMIN : e_top) - MAN_W;
      sh = qe - pe;
      ix = 0;
      if (sh <= 0) begin
        q = p <<< (-sh);
      end else if (sh > 60) begin
        q  = 0;
        ix = 1;
      end else begin
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'sd1 <<< (sh - 1);
        ix   = (rem != 0);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
      if (q == 2048) begin
        q  = 1024;
        qe = qe + 1;
      end
      if (q >= 1024) begin
        fld = qe + MAN_W + BIAS;
        if (fld >= 31) rv = '{{s, 15'h7C00}, 5'b10001};
        else           rv = '{{s, fld[4:0], q[9:0]}, {4'b0000, ix}};
      end else begin
        rv = '{{s, 5'd0, q[9:0]}, {1'b0, ix, (q == 0), 1'b0, ix}};
      end
    end
    return rv;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 9))
      0: v = 16'h0000;
      1: v = {v[15], 15'h7C00};
      2: v = {v[15], 5'd31, v[9:0] | 10'h001};
      3: v = {v[15], 5'd0, v[9:0]};
      4: v = {v[15], 5'd1, v[9:0]};
      5: v = {v[15], 5'd30, v[9:0]};
      default: ;
    endcase
    return v;
  endfunction

  // Scoreboard: every accepted pair enqueues its reference, every consumed result dequeues.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else if (sb_en) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got result %h with nothing pending", result);
        end else begin
          mon_e = sbq.pop_front();
          check("sb_result", {16'h0, result}, {16'h0, mon_e.res});
          check("sb_flags", {27'h0, fl_now}, {27'h0, mon_e.fl});
          out_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back(ref_mul(a, b));
        acc_cnt++;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("vec%0d_latency", idx), cyc, 3);
    check($sformatf("vec%0d_result", idx), {16'h0, result}, {16'h0, v.res});
    check($sformatf("vec%0d_flags", idx), {27'h0, fl_now}, {27'h0, v.fl});
    @(posedge clk); #1;
  endtask

  vec_t        vt[11];
  logic [15:0] pa[5], pb[5];
  logic [15:0] held_r;
  logic [4:0]  held_f;
  exp_t        first_e;
  int          idx, cnt;
  bit          acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    vt[0]  = '{16'hC200, 16'hB9A8, 16'h403E, 5'b00000};
    vt[1]  = '{16'hBC00, 16'h39A8, 16'hB9A8, 5'b00000};
    vt[2]  = '{16'h3C01, 16'h3E00, 16'h3E02, 5'b00001};
    vt[3]  = '{16'h3C01, 16'h3C01, 16'h3C02, 5'b00001};
    vt[4]  = '{16'h7BFF, 16'h4000, 16'h7C00, 5'b10001};
    vt[5]  = '{16'h7C00, 16'h0000, 16'h7E00, 5'b00010};
    vt[6]  = '{16'h7C01, 16'h3C00, 16'h7E00, 5'b00010};
    vt[7]  = '{16'hFC00, 16'h4000, 16'hFC00, 5'b00000};
    vt[8]  = '{16'h0200, 16'h3800, 16'h0100, 5'b00000};
    vt[9]  = '{16'h0001, 16'h3800, 16'h0000, 5'b01101};
    vt[10] = '{16'h0001, 16'h3A00, 16'h0001, 5'b01001};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_result", {16'h0, result}, 0);
    check("rst_flags", {27'h0, fl_now}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'h0, in_ready}, 1);

    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // Stall: five pairs offered back-to-back into a blocked consumer.
    for (int i = 0; i < 5; i++) begin
      pa[i] = rand_op();
      pb[i] = rand_op();
    end
    sb_en = 1; acc_cnt = 0; out_cnt = 0; out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 5);
      a = pa[(idx < 5) ? idx : 4];
      b = pb[(idx < 5) ? idx : 4];
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("stall_accepted", acc_cnt, 3);
    check("stall_in_ready", {31'h0, in_ready}, 0);
    check("stall_out_valid", {31'h0, out_valid}, 1);
    first_e = ref_mul(pa[0], pb[0]);
    check("stall_first_result", {16'h0, result}, {16'h0, first_e.res});
    held_r = result;
    held_f = fl_now;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("stall_hold_result", {16'h0, result}, {16'h0, held_r});
      check("stall_hold_flags", {27'h0, fl_now}, {27'h0, held_f});
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && out_cnt < 5; c++) begin
      in_valid = (idx < 5);
      a = pa[(idx < 5) ? idx : 4];
      b = pb[(idx < 5) ? idx : 4];
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("stall_drain_count", out_cnt, 5);
    check("stall_all_accepted", idx, 5);
    check("stall_queue_empty", sbq.size(), 0);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rand_op();
      b         = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && sbq.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("rand_drain_empty", sbq.size(), 0);

    // Asynchronous reset in the middle of a full pipe.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; a = rand_op(); b = rand_op();
      @(posedge clk); #1;
    end
    check("pre_rst_out_valid", {31'h0, out_valid}, 1);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 0);
    check("midrst_result", {16'h0, result}, 0);
    check("midrst_flags", {27'h0, fl_now}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("post_rst_no_output", cnt, 0);
    check("post_rst_in_ready", {31'h0, in_ready}, 1);
    run_vec(vt[2], 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 binary floating-point multiplier; successor to the fixed-FP16 float_multi.
- Width is generic (EXP_W/MAN_W).
- Adds valid/ready flow control, round-to-nearest-even (RNE), full subnormal support and IEEE exception flags.
- Feeds twiddle-factor multiplication in the FFT butterfly datapath; the default configuration is FP16.

Parameters:
- EXP_W, 5, exponent field width (>=3); bias = 2^(EXP_W-1)-1
- MAN_W, 10, stored fraction width (>=2); W = 1+EXP_W+MAN_W

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A {sign, exp, frac}
- b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  product
- overflow  out  1  rounded result exceeded max finite; result is infinity
- underflow  out  1  result is tiny (subnormal or zero) and inexact
- zero  out  1  result is +/-0
- nan  out  1  result is NaN
- inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Reset (async, rst=1): all stage valids cleared; out_valid=0, result=0, all flags=0. in_ready=1 once reset is released.
- Reset mid-operation discards all in-flight operations; no output appears for them.
- Global advance enable: en = ~out_valid | out_ready.
  - in_ready = en.
  - All three stage registers load only when en=1.
  - Bubbles are not collapsed while stalled.
- Operand transfer: an operand pair is accepted when in_valid & in_ready.
- Result transfer: a result is consumed when out_valid & out_ready.
- While out_valid=1 and out_ready=0, result and all flags are held stable.
- Latency: exactly 3 clk from acceptance to out_valid with no stall. Throughput: 1 result/cycle. Strict in-order; no loss, no duplication.
- S1 (unpack):
  - Classify each operand as zero/subnormal/normal/inf/NaN.
  - Sign = sa ^ sb.
  - Subnormals normalised via leading-zero count.
  - Unbiased exponent sum held in a signed EXP_W+3-bit field.
  - Special-case result and flags resolved here and carried down the pipe.
- S2 (multiply): (MAN_W+1)x(MAN_W+1) significand product, 2*MAN_W+2 bits.
- S3 (normalise/round/pack):
  - Normalise: shift 1 if product >= 2.
  - If exponent < emin, right-shift into the subnormal range, OR-ing shifted-out bits into sticky.
  - Round RNE using guard/round/sticky bits.
  - If the mantissa carries out on rounding, renormalise and increment the exponent.
  - A subnormal that rounds up to 2^emin becomes the minimum normal.
- Special cases:
  - Either operand NaN -> canonical qNaN {0, all-ones exp, frac MSB=1, rest 0} (FP16 0x7E00); nan=1.
  - inf x 0 -> canonical qNaN; nan=1.
  - inf x finite-nonzero or inf x inf -> signed infinity; overflow=0, inexact=0.
  - Either operand zero (other finite) -> signed zero; zero=1.
- Overflow:
  - Rounded exponent > emax -> signed infinity; overflow=1, inexact=1.
- Underflow and zero:
  - underflow=1 only when the result is tiny AND inexact.
  - A tiny result that rounds to 0 gives zero=1, underflow=1, inexact=1, with the sign preserved.
- Flags are qualified by out_valid.
- nan, overflow and zero are mutually exclusive.

Decomposition:
- Package fp_mult_pkg:
  - Functions for W, bias, emax and emin from EXP_W/MAN_W.
  - Operand class enum {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN}.
  - Canonical qNaN construction function.
  - Stage payload struct typedefs.
- Sub-module fp_lzc: parametrised leading-zero counter (width MAN_W). Used in S1 for subnormal normalisation.

Test Plan:
- Basic FP16 product: 0xC200 x 0xB9A8 -> 0x403E, all flags 0, out_valid exactly 3 cycles after acceptance. Also 0xBC00 x 0x39A8 -> 0xB9A8.
- RNE rounding:
  - 0x3C01 x 0x3E00 (exact tie, fraction 513.5) -> 0x3E02, inexact=1.
  - 0x3C01 x 0x3C01 -> 0x3C02, inexact=1.
- Overflow: 0x7BFF x 0x4000 -> 0x7C00, overflow=1, inexact=1.
- NaN and infinity:
  - 0x7C00 x 0x0000 -> 0x7E00, nan=1.
  - 0x7C01 x 0x3C00 -> 0x7E00, nan=1.
  - 0xFC00 x 0x4000 -> 0xFC00, flags 0.
- Subnormals:
  - 0x0200 x 0x3800 -> 0x0100, underflow=0, inexact=0.
  - 0x0001 x 0x3800 -> 0x0000, zero=1, underflow=1, inexact=1.
  - 0x0001 x 0x3A00 -> 0x0001, underflow=1, inexact=1.
- Flow control and reset:
  - Stream 5 random pairs back-to-back with out_ready=0: exactly 3 are accepted, in_ready=0 after, and result stays stable while stalled.
  - Release out_ready: 5 results emerge in order, matching the reference model.
  - Assert rst mid-stream: out_valid drops immediately and no stale result appears afterwards.
